// File: rtl/wishbone_ram_burst.sv
// Wishbone B4 classic slave RAM: programmable wait states, byte-lane writes, ERR on out-of-range.
// Define WB_RAM_BURST_EN to add linear incrementing bursts (CTI=010, BTE=00) at one beat per cycle.
module wishbone_ram_burst #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   wishbone_addr_i,
  input  logic [DATA_WIDTH-1:0]   wishbone_data_i,
  input  logic                    wishbone_we_i,
  input  logic [DATA_WIDTH/8-1:0] wishbone_sel_i,
  input  logic                    wishbone_stb_i,
  input  logic                    wishbone_cyc_i,
  input  logic [2:0]              wishbone_cti_i,
  input  logic [1:0]              wishbone_bte_i,
  output logic [DATA_WIDTH-1:0]   wishbone_data_o,
  output logic                    wishbone_ack_o,
  output logic                    wishbone_err_o
);
  localparam int NB    = DATA_WIDTH / 8;
  localparam int AL    = $clog2(NB);
  localparam int IW    = DEPTH_LOG2 + AL;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_BURST} state_t;

  state_t                r_state, w_state_next;
  logic [3:0]            r_cnt, w_cnt_next;
  logic [DEPTH_LOG2-1:0] r_idx, w_idx_next;
  logic [DATA_WIDTH-1:0] r_data;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_req, w_oor, w_ack, w_err;
  logic                  w_wr_en, w_rd_en, w_rd_zero;
  logic [DEPTH_LOG2-1:0] w_addr_idx, w_wr_idx, w_rd_idx;
  logic [DATA_WIDTH-1:0] w_lane_mask;
  logic                  w_unused;

  assign w_req      = wishbone_stb_i & wishbone_cyc_i;
  assign w_addr_idx = wishbone_addr_i[IW-1:AL];
  assign w_unused   = ^{wishbone_addr_i, wishbone_cti_i, wishbone_bte_i};

  generate
    if (ADDR_WIDTH > IW) begin : g_range
      assign w_oor = |wishbone_addr_i[ADDR_WIDTH-1:IW];
    end else begin : g_no_range
      assign w_oor = 1'b0;
    end
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      assign w_lane_mask[gi*8 +: 8] = {8{wishbone_sel_i[gi]}};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_idx   <= w_idx_next;
      // Read data is fetched one cycle ahead so it is already registered when ACK rises.
      if (w_rd_en) r_data <= w_rd_zero ? '0 : (r_mem[w_rd_idx] & w_lane_mask);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (wishbone_sel_i[b]) r_mem[w_wr_idx][b*8 +: 8] <= wishbone_data_i[b*8 +: 8];
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_idx_next   = r_idx;
    w_ack        = 1'b0;
    w_err        = 1'b0;
    w_wr_en      = 1'b0;
    w_wr_idx     = w_addr_idx;
    w_rd_en      = 1'b0;
    w_rd_idx     = w_addr_idx;
    w_rd_zero    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_cnt_next = 4'(WAIT_STATES);
          if (WAIT_STATES == 0) begin
            w_state_next = S_RESP;
            w_rd_en      = 1'b1;
            w_rd_zero    = w_oor;
          end else begin
            w_state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!w_req) begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
          if (r_cnt <= 4'd1) begin
            w_state_next = S_RESP;
            w_rd_en      = 1'b1;
            w_rd_zero    = w_oor;
          end
        end
      end
      S_RESP: begin
        w_state_next = S_IDLE;
        w_ack        = w_req & ~w_oor;
        w_err        = w_req & w_oor;
        w_wr_en      = w_ack & wishbone_we_i;
`ifdef WB_RAM_BURST_EN
        if (w_ack && wishbone_cti_i == 3'b010 && wishbone_bte_i == 2'b00) begin
          w_state_next = S_BURST;
          w_idx_next   = w_addr_idx + DEPTH_LOG2'(1);
          w_rd_en      = 1'b1;
          w_rd_idx     = w_addr_idx + DEPTH_LOG2'(1);
        end
`endif
      end
`ifdef WB_RAM_BURST_EN
      S_BURST: begin
        // Internal index drives the beat; stb low with cyc high is a master wait state.
        if (!wishbone_cyc_i) begin
          w_state_next = S_IDLE;
        end else if (wishbone_stb_i) begin
          w_ack      = 1'b1;
          w_wr_en    = wishbone_we_i;
          w_wr_idx   = r_idx;
          w_idx_next = r_idx + DEPTH_LOG2'(1);
          w_rd_en    = 1'b1;
          w_rd_idx   = r_idx + DEPTH_LOG2'(1);
          if (wishbone_cti_i != 3'b010) w_state_next = S_IDLE;
        end
      end
`endif
      default: w_state_next = S_IDLE;
    endcase
  end

  assign wishbone_data_o = r_data;
  assign wishbone_ack_o  = w_ack;
  assign wishbone_err_o  = w_err;

endmodule

// File: tb/tb_wishbone_ram_burst.sv
// Randomised self-checking bench for wishbone_ram_burst (32-bit, 1024 words, one wait state).
// Burst scenarios run only when WB_RAM_BURST_EN is defined.
module tb_wishbone_ram_burst;
  localparam int WS = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr, wdata, rdata;
  logic        we, stb, cyc, ack, err;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;

  int checks   = 0;
  int failures = 0;
  logic [31:0] model_mem [1024];

  always #5 clk = ~clk;

  wishbone_ram_burst #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_LOG2(10), .WAIT_STATES(WS)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wishbone_addr_i(addr), .wishbone_data_i(wdata), .wishbone_we_i(we),
    .wishbone_sel_i(sel), .wishbone_stb_i(stb), .wishbone_cyc_i(cyc),
    .wishbone_cti_i(cti), .wishbone_bte_i(bte),
    .wishbone_data_o(rdata), .wishbone_ack_o(ack), .wishbone_err_o(err)
  );

  // One classic transfer; lat = negedges from request to ACK/ERR (-1 on timeout).
  task automatic wb_xfer(input logic [31:0] a, input logic [31:0] d, input logic w,
                         input logic [3:0] s, output logic [31:0] rd,
                         output logic got_ack, output logic got_err, output int lat);
    @(posedge clk); #1;
    addr = a; wdata = d; we = w; sel = s; cti = 3'b000; bte = 2'b00; stb = 1'b1; cyc = 1'b1;
    lat = -1; rd = '0; got_ack = 1'b0; got_err = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ack === 1'b1 || err === 1'b1) begin
        lat = i; rd = rdata; got_ack = ack; got_err = err;
        break;
      end
    end
    @(posedge clk); #1;
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    $display("xfer addr=%08h we=%0b sel=%04b wdata=%08h -> ack=%0b err=%0b rdata=%08h lat=%0d",
             a, w, s, d, got_ack, got_err, rd, lat);
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] s);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) if (s[b]) m[b*8 +: 8] = 8'hFF;
    return m;
  endfunction

  task automatic test_reset;
    @(negedge clk);
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b want=0", ack); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want=0", err); end
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL reset_data got=%08h want=00000000", rdata); end
    rst_n = 1'b1;
  endtask

  task automatic init_pool;
    logic [31:0] rd, d; logic a, e; int lat;
    for (int w = 0; w < 1024; w++) begin
      if (w < 16 || w >= 1022) begin
        d = $urandom;
        wb_xfer(32'(w * 4), d, 1'b1, 4'hF, rd, a, e, lat);
        model_mem[w] = d;
      end
    end
  endtask

  task automatic test_reset_mid_wait;
    logic [31:0] rd; logic a, e; int lat;
    wb_xfer(32'h14, 32'hCAFEF00D, 1'b1, 4'hF, rd, a, e, lat);
    model_mem[5] = 32'hCAFEF00D;
    wb_xfer(32'h14, 32'h0, 1'b0, 4'hF, rd, a, e, lat);
    checks++; if (rd !== 32'hCAFEF00D) begin failures++; $display("FAIL rst_pre_read got=%08h want=cafef00d", rd); end
    @(posedge clk); #1;
    addr = 32'h14; wdata = 32'h0BAD0BAD; we = 1'b1; sel = 4'hF; stb = 1'b1; cyc = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0; #1;
    checks++; if (ack !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL rst_mid_ackerr got=%b%b want=00", ack, err); end
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL rst_mid_data got=%08h want=00000000", rdata); end
    @(posedge clk); #1;
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    wb_xfer(32'h14, 32'h0, 1'b0, 4'hF, rd, a, e, lat);
    checks++; if (rd !== 32'hCAFEF00D) begin failures++; $display("FAIL rst_word_kept got=%08h want=cafef00d", rd); end
  endtask

  task automatic test_basic;
    logic [31:0] rd; logic a, e; int lat;
    wb_xfer(32'h10, 32'hDEADBEEF, 1'b1, 4'hF, rd, a, e, lat);
    model_mem[4] = 32'hDEADBEEF;
    checks++; if (a !== 1'b1 || e !== 1'b0) begin failures++; $display("FAIL basic_wr_ack got ack=%b err=%b want 1 0", a, e); end
    checks++; if (lat != WS + 1) begin failures++; $display("FAIL basic_wr_lat got=%0d want=%0d", lat, WS + 1); end
    wb_xfer(32'h10, 32'h0, 1'b0, 4'hF, rd, a, e, lat);
    checks++; if (lat != WS + 1) begin failures++; $display("FAIL basic_rd_lat got=%0d want=%0d", lat, WS + 1); end
    checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL basic_rd_data got=%08h want=deadbeef", rd); end
  endtask

  task automatic test_byte_lanes;
    logic [31:0] rd; logic a, e; int lat;
    wb_xfer(32'h10, 32'h11223344, 1'b1, 4'b0101, rd, a, e, lat);
    model_mem[4] = 32'hDE22BE44;
    wb_xfer(32'h10, 32'h0, 1'b0, 4'hF, rd, a, e, lat);
    checks++; if (rd !== 32'hDE22BE44) begin failures++; $display("FAIL lanes_full got=%08h want=de22be44", rd); end
    wb_xfer(32'h13, 32'h0, 1'b0, 4'b0011, rd, a, e, lat);
    checks++; if (rd !== 32'h0000BE44) begin failures++; $display("FAIL lanes_partial got=%08h want=0000be44", rd); end
  endtask

  task automatic test_range;
    logic [31:0] rd; logic a, e; int lat;
    wb_xfer(32'h00001000, 32'h0, 1'b0, 4'hF, rd, a, e, lat);
    checks++; if (e !== 1'b1 || a !== 1'b0) begin failures++; $display("FAIL range_rd got ack=%b err=%b want 0 1", a, e); end
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL range_rd_data got=%08h want=00000000", rd); end
    wb_xfer(32'h00001000, 32'h12345678, 1'b1, 4'hF, rd, a, e, lat);
    checks++; if (e !== 1'b1 || a !== 1'b0) begin failures++; $display("FAIL range_wr got ack=%b err=%b want 0 1", a, e); end
    wb_xfer(32'h0, 32'h0, 1'b0, 4'hF, rd, a, e, lat);
    checks++; if (rd !== model_mem[0]) begin failures++; $display("FAIL range_alias got=%08h want=%08h", rd, model_mem[0]); end
  endtask

  task automatic test_abort;
    logic [31:0] rd; logic a, e; int lat; logic saw;
    @(posedge clk); #1;
    addr = 32'h20; wdata = ~model_mem[8]; we = 1'b1; sel = 4'hF; stb = 1'b1; cyc = 1'b1;
    @(posedge clk); #1;
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ack !== 1'b0 || err !== 1'b0) saw = 1'b1;
    end
    checks++; if (saw !== 1'b0) begin failures++; $display("FAIL abort_ack got=1 want=0"); end
    wb_xfer(32'h20, 32'h0, 1'b0, 4'hF, rd, a, e, lat);
    checks++; if (rd !== model_mem[8]) begin failures++; $display("FAIL abort_word got=%08h want=%08h", rd, model_mem[8]); end
  endtask

  task automatic test_back_to_back;
    int words [4] = '{1, 2, 3, 4};
    int n, k, last;
    n = 0; k = 0; last = 0;
    @(posedge clk); #1;
    addr = 32'(words[0] * 4); we = 1'b0; sel = 4'hF; cti = 3'b000; stb = 1'b1; cyc = 1'b1;
    while (k < 4 && n < 60) begin
      @(negedge clk); n++;
      if (ack === 1'b1) begin
        $display("b2b beat=%0d cycle=%0d rdata=%08h", k, n, rdata);
        checks++; if (rdata !== model_mem[words[k]]) begin failures++; $display("FAIL b2b_data beat=%0d got=%08h want=%08h", k, rdata, model_mem[words[k]]); end
        if (k > 0) begin
          checks++; if (n - last != WS + 2) begin failures++; $display("FAIL b2b_interval got=%0d want=%0d", n - last, WS + 2); end
        end
        last = n; k++;
        @(posedge clk); #1;
        if (k < 4) addr = 32'(words[k] * 4);
        @(negedge clk); n++;
        checks++; if (ack !== 1'b0) begin failures++; $display("FAIL b2b_dead_cycle got=%b want=0", ack); end
      end
    end
    checks++; if (k != 4) begin failures++; $display("FAIL b2b_timeout beats=%0d want=4", k); end
    @(posedge clk); #1;
    stb = 1'b0; cyc = 1'b0;
  endtask

  task automatic test_random;
    logic [31:0] rd, a32, d, exp; logic a, e, w, oor; logic [3:0] s; logic [9:0] idx; int pi, lat;
    for (int t = 0; t < 60; t++) begin
      pi  = int'($urandom_range(0, 17));
      idx = (pi < 16) ? 10'(pi) : 10'(1006 + pi);
      a32 = {20'd0, idx, 2'($urandom_range(0, 3))};
      oor = ($urandom_range(0, 7) == 0);
      if (oor) a32[$urandom_range(12, 31)] = 1'b1;
      w = 1'($urandom_range(0, 1));
      s = 4'($urandom_range(0, 15));
      d = $urandom;
      exp = oor ? 32'h0 : (model_mem[idx] & lane_mask(s));
      wb_xfer(a32, d, w, s, rd, a, e, lat);
      checks++; if (a !== !oor || e !== oor) begin failures++; $display("FAIL rand_resp t=%0d got ack=%b err=%b want ack=%b err=%b", t, a, e, !oor, oor); end
      checks++; if (lat != WS + 1) begin failures++; $display("FAIL rand_lat t=%0d got=%0d want=%0d", t, lat, WS + 1); end
      if (!w || oor) begin
        checks++; if (rd !== exp) begin failures++; $display("FAIL rand_rdata t=%0d got=%08h want=%08h", t, rd, exp); end
      end
      if (w && !oor) model_mem[idx] = (model_mem[idx] & ~lane_mask(s)) | (d & lane_mask(s));
    end
  endtask

`ifdef WB_RAM_BURST_EN
  task automatic test_burst;
    logic [31:0] rd, exp; logic a, e; int lat, n, k, first; logic stalled;
    logic [31:0] bd [3];
    n = 0; k = 0; first = 0;
    @(posedge clk); #1;
    addr = 32'(1022 * 4); we = 1'b0; sel = 4'hF; cti = 3'b010; bte = 2'b00; stb = 1'b1; cyc = 1'b1;
    while (k < 4 && n < 40) begin
      @(negedge clk); n++;
      if (ack === 1'b1) begin
        exp = model_mem[(1022 + k) % 1024];
        $display("burst_rd beat=%0d cycle=%0d rdata=%08h", k, n, rdata);
        checks++; if (rdata !== exp) begin failures++; $display("FAIL burst_rd_data beat=%0d got=%08h want=%08h", k, rdata, exp); end
        if (k == 0) begin
          first = n;
          checks++; if (n - 1 != WS + 1) begin failures++; $display("FAIL burst_first_lat got=%0d want=%0d", n - 1, WS + 1); end
        end else begin
          checks++; if (n != first + k) begin failures++; $display("FAIL burst_consecutive beat=%0d got=%0d want=%0d", k, n, first + k); end
        end
        k++;
        @(posedge clk); #1;
        addr = 32'(((1022 + k) % 1024) * 4);
        cti  = (k == 3) ? 3'b111 : 3'b010;
      end
    end
    checks++; if (k != 4) begin failures++; $display("FAIL burst_rd_timeout beats=%0d want=4", k); end
    stb = 1'b0; cyc = 1'b0; cti = 3'b000;
    wb_xfer(32'h8, 32'h0, 1'b0, 4'hF, rd, a, e, lat);
    checks++; if (lat != WS + 1 || rd !== model_mem[2]) begin failures++; $display("FAIL burst_idle_after got lat=%0d data=%08h want lat=%0d data=%08h", lat, rd, WS + 1, model_mem[2]); end

    for (int i = 0; i < 3; i++) bd[i] = $urandom;
    n = 0; k = 0; stalled = 1'b0;
    @(posedge clk); #1;
    addr = 32'h0C; wdata = bd[0]; we = 1'b1; sel = 4'hF; cti = 3'b010; stb = 1'b1; cyc = 1'b1;
    while (k < 3 && n < 40) begin
      @(negedge clk); n++;
      if (ack === 1'b1) begin
        model_mem[3 + k] = bd[k];
        k++;
        @(posedge clk); #1;
        if (k == 1 && !stalled) begin
          stb = 1'b0; stalled = 1'b1;
          @(negedge clk); n++;
          checks++; if (ack !== 1'b0) begin failures++; $display("FAIL burst_stall_ack got=%b want=0", ack); end
          @(posedge clk); #1;
          stb = 1'b1;
        end
        if (k < 3) begin
          wdata = bd[k]; addr = 32'((3 + k) * 4);
          cti = (k == 2) ? 3'b111 : 3'b010;
        end
      end
    end
    checks++; if (k != 3) begin failures++; $display("FAIL burst_wr_timeout beats=%0d want=3", k); end
    stb = 1'b0; cyc = 1'b0; we = 1'b0; cti = 3'b000;
    for (int w = 3; w < 6; w++) begin
      wb_xfer(32'(w * 4), 32'h0, 1'b0, 4'hF, rd, a, e, lat);
      checks++; if (rd !== model_mem[w]) begin failures++; $display("FAIL burst_wr_word w=%0d got=%08h want=%08h", w, rd, model_mem[w]); end
    end
  endtask
`endif

  initial begin
    rst_n = 1'b1;
    addr = '0; wdata = '0; we = 1'b0; sel = '0; stb = 1'b0; cyc = 1'b0; cti = '0; bte = '0;
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    test_reset;
    init_pool;
    test_reset_mid_wait;
    test_basic;
    test_byte_lanes;
    test_range;
    test_abort;
    test_back_to_back;
    test_random;
`ifdef WB_RAM_BURST_EN
    test_burst;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout reached want=finish");
    $fatal(1);
  end

endmodule
